// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
// Patterns are written a..g left to right, active low (0 = lit).
package seg7_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct packed {
    logic [3:0] nib;
    logic       err;
  } slot_t;

  // A strobe is a real digit select only when exactly one line is pulled low.
  function automatic logic an_onehot0(input logic [3:0] an);
    return $countones(~an) == 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to hex-nibble decoder.
// Anything outside the sixteen glyphs (blank included) is flagged illegal.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] nibble,
  output logic       illegal
);

  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 7-segment display bus and rebuilds the 4-digit
// hex value, emitting one hex_valid pulse per complete frame.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [0:6]  seg,
  input  logic [3:0]  an,
  output logic [15:0] hex_value,
  output logic [3:0]  hex_err,
  output logic        hex_valid
);

  localparam logic [7:0] CMAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CHIT = 8'(STABLE_CYCLES - 2);

  logic [3:0] an_s1, an_s2, an_p;
  logic [0:6] seg_s1, seg_s2, seg_p;
  logic [7:0] cnt;
  logic       same, hit, full;
  logic [3:0] mask;
  slot_t      dec;
  slot_t [3:0] slots;

  // Sync stages plus one history stage for change detection; idle = blank, no strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_s1  <= 4'hF;
      an_s2  <= 4'hF;
      an_p   <= 4'hF;
      seg_s1 <= SEG_BLANK;
      seg_s2 <= SEG_BLANK;
      seg_p  <= SEG_BLANK;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  seg7_decode u_dec (
    .seg     (seg_s2),
    .nibble  (dec.nib),
    .illegal (dec.err)
  );

  assign same = (an_s2 == an_p) && (seg_s2 == seg_p);
  // Counter saturates at CMAX, so a single dwell can only hit once.
  assign hit  = same && (cnt == CHIT) && an_onehot0(an_s2);
  assign full = &mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         cnt <= 8'd0;
    else if (!same)      cnt <= 8'd0;
    else if (cnt != CMAX) cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slots <= '0;
    end else if (hit) begin
      for (int i = 0; i < 4; i++)
        if (!an_s2[i]) slots[i] <= dec;
    end
  end

  // A digit landing on the clearing cycle seeds the next frame's mask.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   mask <= 4'h0;
    else if (full) mask <= hit ? ~an_s2 : 4'h0;
    else if (hit)  mask <= mask | ~an_s2;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex_value <= 16'h0000;
      hex_err   <= 4'h0;
      hex_valid <= 1'b0;
    end else begin
      hex_valid <= full;
      if (full) begin
        for (int i = 0; i < 4; i++) begin
          hex_value[4*i +: 4] <= slots[i].nib;
          hex_err[i]          <= slots[i].err;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor
// pops and compares on every hex_valid and checks hold/pulse behaviour.
module tb_seg7_scan_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] hex_value;
  logic [3:0]  hex_err;
  logic        hex_valid;

  seg7_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .seg       (seg),
    .an        (an),
    .hex_value (hex_value),
    .hex_err   (hex_err),
    .hex_valid (hex_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  e;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t_onset = 0;
  bit          lat_chk = 0;
  logic [15:0] held_v = 16'h0;
  logic [3:0]  held_e = 4'h0;
  bit          prev_v = 0;

  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      held_v = 16'h0;
      held_e = 4'h0;
      prev_v = 0;
    end else begin
      if (hex_valid) begin
        total++;
        if (prev_v) begin
          bad++;
          $display("FAIL pulse_width: hex_valid high two cycles at cyc %0d", cyc);
        end
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: value=%h err=%b, none expected", hex_value, hex_err);
        end else begin
          e = q.pop_front();
          if (hex_value !== e.v || hex_err !== e.e) begin
            bad++;
            $display("FAIL frame: got value=%h err=%b, want value=%h err=%b",
                     hex_value, hex_err, e.v, e.e);
          end
          held_v = e.v;
          held_e = e.e;
          if (lat_chk) begin
            lat_chk = 0;
            total++;
            if (cyc - t_onset != S + 3) begin
              bad++;
              $display("FAIL latency: got %0d cycles, want %0d", cyc - t_onset, S + 3);
            end
          end
        end
      end else begin
        total++;
        if (hex_value !== held_v || hex_err !== held_e) begin
          bad++;
          $display("FAIL hold: got value=%h err=%b, want value=%h err=%b",
                   hex_value, hex_err, held_v, held_e);
        end
      end
      prev_v = hex_valid;
    end
  end

  task automatic show(input int d, input logic [6:0] p, input int n);
    an  = ~(4'b0001 << d);
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic gap(input logic [3:0] a, input int n);
    an  = a;
    seg = pat[8];
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] e);
    exp_t x;
    x.v = v;
    x.e = e;
    q.push_back(x);
  endtask

  task automatic check_zero(input string nm);
    total++;
    if (hex_value !== 16'h0 || hex_err !== 4'h0 || hex_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s: got value=%h err=%b valid=%b, want 0/0/0",
               nm, hex_value, hex_err, hex_valid);
    end
  endtask

  initial begin
    resetn = 1'b0;
    an     = 4'hF;
    seg    = BLANK;
    #23;
    check_zero("reset_state");
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("post_reset_idle");

    // Digits A B C D, with latency measured on the final digit.
    expect_frame(16'hABCD, 4'h0);
    show(3, pat[10], 8);
    show(2, pat[11], 8);
    show(1, pat[12], 8);
    t_onset = cyc;
    lat_chk = 1;
    show(0, pat[13], 8);
    gap(4'hF, 6);

    // Blank on digit 1 is an illegal glyph.
    expect_frame(16'h1101, 4'b0010);
    show(3, pat[1], 8);
    show(2, pat[1], 8);
    show(1, BLANK, 8);
    show(0, pat[1], 8);
    gap(4'hF, 6);

    // Short dwell on digit 2 must not latch.
    show(3, pat[5], 8);
    show(2, pat[6], S - 1);
    gap(4'hF, 4);
    show(1, pat[7], 8);
    show(0, pat[8], 8);
    gap(4'hF, 10);
    expect_frame(16'h5678, 4'h0);
    show(2, pat[6], 8);
    gap(4'hF, 6);

    // Gaps with zero or multiple strobes are ignored.
    expect_frame(16'h9E0F, 4'h0);
    show(3, pat[9], 8);
    gap(4'b0011, 6);
    show(2, pat[14], 8);
    gap(4'b1111, 6);
    show(1, pat[0], 8);
    gap(4'b0011, 6);
    show(0, pat[15], 8);
    gap(4'hF, 6);

    // Reset after three digits drops the partial frame.
    show(3, pat[2], 8);
    show(2, pat[3], 8);
    show(1, pat[4], 8);
    resetn = 1'b0;
    #1;
    check_zero("async_reset");
    gap(4'hF, 2);
    resetn = 1'b1;
    gap(4'hF, 2);
    check_zero("reset_release");
    show(0, pat[12], 8);
    gap(4'hF, 12);
    expect_frame(16'hDEFC, 4'h0);
    show(3, pat[13], 8);
    show(2, pat[14], 8);
    show(1, pat[15], 8);
    gap(4'hF, 6);

    // Continuous scan of 1234.
    for (int k = 0; k < 3; k++) begin
      expect_frame(16'h1234, 4'h0);
      show(3, pat[1], 6);
      show(2, pat[2], 6);
      show(1, pat[3], 6);
      show(0, pat[4], 6);
    end
    gap(4'hF, 4);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d frames still outstanding, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
